// File: rtl/ahblite_slave_mux_pkg.sv
// Shared AHB-Lite types for the slave return-path mux: transfer/response codes,
// data-phase select encoding and default-slave error FSM states.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    SEL_NONE = 3'd0,
    SEL_P0   = 3'd1,
    SEL_P1   = 3'd2,
    SEL_P2   = 3'd3,
    SEL_P3   = 3'd4,
    SEL_DEF  = 3'd5
  } sel_e;

  typedef enum logic [1:0] {
    ERR_OK = 2'd0,
    ERR_1  = 2'd1,
    ERR_2  = 2'd2
  } errfsm_e;

endpackage

// File: rtl/ahblite_slave_mux_if.sv
// Bus-side signals of the AHB-Lite return-path mux: master-side address-phase
// controls, the four slave ports and the muxed response back to the master.
interface ahblite_slave_mux_if;

  // Handshake: an address phase is accepted on a rising HCLK edge with HREADY=1;
  // a data phase completes on the edge where HREADYOUT=1, and HRESP/HRDATA are
  // only meaningful on that edge (ERROR uses a two-cycle response).
  logic        HSEL_M;
  logic [1:0]  HTRANS;
  logic        HREADY;

  logic        P0_HSEL,      P1_HSEL,      P2_HSEL,      P3_HSEL;
  logic        P0_HREADYOUT, P1_HREADYOUT, P2_HREADYOUT, P3_HREADYOUT;
  logic        P0_HRESP,     P1_HRESP,     P2_HRESP,     P3_HRESP;
  logic [31:0] P0_HRDATA,    P1_HRDATA,    P2_HRDATA,    P3_HRDATA;

  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;

  modport master (
    output HSEL_M, HTRANS, HREADY,
    output P0_HSEL, P1_HSEL, P2_HSEL, P3_HSEL,
    output P0_HREADYOUT, P1_HREADYOUT, P2_HREADYOUT, P3_HREADYOUT,
    output P0_HRESP, P1_HRESP, P2_HRESP, P3_HRESP,
    output P0_HRDATA, P1_HRDATA, P2_HRDATA, P3_HRDATA,
    input  HREADYOUT, HRESP, HRDATA
  );

  modport slave (
    input  HSEL_M, HTRANS, HREADY,
    input  P0_HSEL, P1_HSEL, P2_HSEL, P3_HSEL,
    input  P0_HREADYOUT, P1_HREADYOUT, P2_HREADYOUT, P3_HREADYOUT,
    input  P0_HRESP, P1_HRESP, P2_HRESP, P3_HRESP,
    input  P0_HRDATA, P1_HRDATA, P2_HRDATA, P3_HRDATA,
    output HREADYOUT, HRESP, HRDATA
  );

endinterface

// File: rtl/ahblite_slave_mux_default_slave.sv
// Default slave: two-cycle ERROR FSM for unclaimed transfers and, when
// AHB_MUX_TIMEOUT_EN is defined, a wait-state watchdog on the routed slave.
module ahblite_default_slave
  import ahb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    i_start,
  input  logic    i_stall,
  input  logic    i_load,
  output logic    o_hreadyout,
  output logic    o_hresp,
  output logic    o_active,
  output errfsm_e o_state
);

  errfsm_e r_state;
  errfsm_e w_next_state;
  logic    w_timeout;

`ifdef AHB_MUX_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_wait_cnt;

  // Firing on the stall that would make the count reach the limit lets a slave
  // answering in that very cycle win.
  assign w_timeout = i_stall && (r_state == ERR_OK) &&
                     (r_wait_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
    end else if (i_load) begin
      r_wait_cnt <= '0;
    end else if (i_stall && (r_state == ERR_OK)) begin
      r_wait_cnt <= r_wait_cnt + CW'(1);
    end
  end
`else
  localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
  logic w_unused_inputs;
  assign w_unused_inputs = i_stall ^ i_load;
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ERR_OK;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ERR_OK:  if (i_start || w_timeout) w_next_state = ERR_1;
      ERR_1:   w_next_state = ERR_2;
      ERR_2:   w_next_state = i_start ? ERR_1 : ERR_OK;
      default: w_next_state = ERR_OK;
    endcase
  end

  always_comb begin
    o_hreadyout = 1'b1;
    o_hresp     = HRESP_OKAY;
    o_active    = 1'b0;
    case (r_state)
      ERR_1: begin
        o_hreadyout = 1'b0;
        o_hresp     = HRESP_ERROR;
        o_active    = 1'b1;
      end
      ERR_2: begin
        o_hreadyout = 1'b1;
        o_hresp     = HRESP_ERROR;
        o_active    = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_state = r_state;

endmodule

// File: rtl/ahblite_slave_mux.sv
// AHB-Lite return-path mux: latches the decoder's port select in the address
// phase and routes that slave's response in the data phase. Optional watchdog: AHB_MUX_TIMEOUT_EN.
module ahblite_slave_mux
  import ahb_pkg::*;
#(
  parameter bit          Port0_en       = 1'b1,
  parameter bit          Port1_en       = 1'b1,
  parameter bit          Port2_en       = 1'b1,
  parameter bit          Port3_en       = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  ahblite_slave_mux_if.slave  bus,
  output sel_e                o_dbg_sel,
  output errfsm_e             o_dbg_state
);

  logic [3:0]  w_port_en;
  logic [3:0]  w_hsel;
  logic [3:0]  w_p_rdy;
  logic [3:0]  w_p_resp;
  logic [31:0] w_p_rdata [4];

  assign w_port_en    = {Port3_en, Port2_en, Port1_en, Port0_en};
  assign w_hsel       = {bus.P3_HSEL, bus.P2_HSEL, bus.P1_HSEL, bus.P0_HSEL};
  assign w_p_rdy      = {bus.P3_HREADYOUT, bus.P2_HREADYOUT, bus.P1_HREADYOUT, bus.P0_HREADYOUT};
  assign w_p_resp     = {bus.P3_HRESP, bus.P2_HRESP, bus.P1_HRESP, bus.P0_HRESP};
  assign w_p_rdata[0] = bus.P0_HRDATA;
  assign w_p_rdata[1] = bus.P1_HRDATA;
  assign w_p_rdata[2] = bus.P2_HRDATA;
  assign w_p_rdata[3] = bus.P3_HRDATA;

  logic w_unused_htrans;
  assign w_unused_htrans = bus.HTRANS[0];

  sel_e r_sel_q;
  sel_e w_next_sel;

  // Descending scan so the lowest enabled, selected port ends up winning.
  always_comb begin
    w_next_sel = SEL_NONE;
    if (bus.HSEL_M && bus.HTRANS[1]) w_next_sel = SEL_DEF;
    for (int i = 3; i >= 0; i--) begin
      if (w_port_en[i] && w_hsel[i]) w_next_sel = sel_e'(3'(i + 1));
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_sel_q <= SEL_NONE;
    end else if (bus.HREADY) begin
      r_sel_q <= w_next_sel;
    end
  end

  logic       w_port_hit;
  logic [1:0] w_port_idx;

  always_comb begin
    w_port_hit = 1'b0;
    w_port_idx = 2'd0;
    case (r_sel_q)
      SEL_P0: begin w_port_hit = 1'b1; w_port_idx = 2'd0; end
      SEL_P1: begin w_port_hit = 1'b1; w_port_idx = 2'd1; end
      SEL_P2: begin w_port_hit = 1'b1; w_port_idx = 2'd2; end
      SEL_P3: begin w_port_hit = 1'b1; w_port_idx = 2'd3; end
      default: ;
    endcase
  end

  logic w_start;
  logic w_stall;
  logic w_def_hready;
  logic w_def_hresp;
  logic w_def_active;

  assign w_start = bus.HREADY && (w_next_sel == SEL_DEF);
  assign w_stall = w_port_hit && !w_p_rdy[w_port_idx];

  ahblite_default_slave #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_def (
    .clk         (HCLK),
    .rst_n       (HRESETn),
    .i_start     (w_start),
    .i_stall     (w_stall),
    .i_load      (bus.HREADY),
    .o_hreadyout (w_def_hready),
    .o_hresp     (w_def_hresp),
    .o_active    (w_def_active),
    .o_state     (o_dbg_state)
  );

  // An active error response overrides the routed port, which is how a timed-out
  // slave stops being followed.
  always_comb begin
    bus.HREADYOUT = 1'b1;
    bus.HRESP     = HRESP_OKAY;
    bus.HRDATA    = '0;
    if (w_def_active) begin
      bus.HREADYOUT = w_def_hready;
      bus.HRESP     = w_def_hresp;
    end else if (w_port_hit) begin
      bus.HREADYOUT = w_p_rdy[w_port_idx];
      bus.HRESP     = w_p_resp[w_port_idx];
      bus.HRDATA    = w_p_rdata[w_port_idx];
    end
  end

  assign o_dbg_sel = r_sel_q;

endmodule

// File: tb/tb_ahblite_slave_mux.sv
// Bench for ahblite_slave_mux: directed vector table, reset/timeout sequences
// and randomized traffic against a cycle-level reference model.
module tb_ahblite_slave_mux;
  import ahb_pkg::*;

  localparam logic [3:0] PEN = 4'b1101;
  localparam int         TMO = 4;

  logic HCLK    = 1'b0;
  logic HRESETn = 1'b0;
  always #5 HCLK = ~HCLK;

  ahblite_slave_mux_if bus();

  sel_e    dbg_sel;
  errfsm_e dbg_state;

  logic        t_hsel_m;
  logic [1:0]  t_htrans;
  logic        t_hready;
  logic [3:0]  t_hsel;
  logic [3:0]  t_rdy;
  logic [3:0]  t_resp;
  logic [31:0] t_rdata [4];

  assign bus.HSEL_M       = t_hsel_m;
  assign bus.HTRANS       = t_htrans;
  assign bus.HREADY       = t_hready;
  assign bus.P0_HSEL      = t_hsel[0];
  assign bus.P1_HSEL      = t_hsel[1];
  assign bus.P2_HSEL      = t_hsel[2];
  assign bus.P3_HSEL      = t_hsel[3];
  assign bus.P0_HREADYOUT = t_rdy[0];
  assign bus.P1_HREADYOUT = t_rdy[1];
  assign bus.P2_HREADYOUT = t_rdy[2];
  assign bus.P3_HREADYOUT = t_rdy[3];
  assign bus.P0_HRESP     = t_resp[0];
  assign bus.P1_HRESP     = t_resp[1];
  assign bus.P2_HRESP     = t_resp[2];
  assign bus.P3_HRESP     = t_resp[3];
  assign bus.P0_HRDATA    = t_rdata[0];
  assign bus.P1_HRDATA    = t_rdata[1];
  assign bus.P2_HRDATA    = t_rdata[2];
  assign bus.P3_HRDATA    = t_rdata[3];

  ahblite_slave_mux #(
    .Port0_en       (PEN[0]),
    .Port1_en       (PEN[1]),
    .Port2_en       (PEN[2]),
    .Port3_en       (PEN[3]),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .bus         (bus),
    .o_dbg_sel   (dbg_sel),
    .o_dbg_state (dbg_state)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [33:0] exp_q[$];

  task automatic chk(input string nm, input logic [33:0] act, input logic [33:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: which port owns the data phase (-1 none, 0..3 port, 4 default),
  // how many ERROR cycles remain, and how long the routed slave has stalled.
  int m_sel, m_err, m_wait;

  task automatic model_reset();
    m_sel = -1; m_err = 0; m_wait = 0;
  endtask

  function automatic logic [33:0] model_out();
    if (m_err == 2) return {1'b0, 1'b1, 32'h0};
    if (m_err == 1) return {1'b1, 1'b1, 32'h0};
    if (m_sel >= 0 && m_sel < 4) return {t_rdy[m_sel], t_resp[m_sel], t_rdata[m_sel]};
    return {1'b1, 1'b0, 32'h0};
  endfunction

  task automatic model_step();
    int  ns;
    bit  stall, tmo, start;
    ns = -1;
    if (t_hsel_m && t_htrans[1]) ns = 4;
    for (int i = 3; i >= 0; i--) if (PEN[i] && t_hsel[i]) ns = i;
    stall = (m_err == 0) && (m_sel >= 0) && (m_sel < 4) && !t_rdy[m_sel];
    tmo = 1'b0;
`ifdef AHB_MUX_TIMEOUT_EN
    tmo = stall && (m_wait + 1 == TMO);
`endif
    start = t_hready && (ns == 4);
    if (m_err == 2) m_err = 1;
    else if (start || tmo) m_err = 2;
    else m_err = 0;
    if (t_hready) m_wait = 0;
    else if (stall) m_wait++;
    if (t_hready) m_sel = ns;
  endtask

  task automatic drive(input logic hs, input logic [1:0] ht, input logic [3:0] sel,
                       input logic [3:0] rdy, input logic [3:0] resp, input logic hr);
    t_hsel_m = hs; t_htrans = ht; t_hsel = sel; t_rdy = rdy; t_resp = resp; t_hready = hr;
  endtask

  // One bus cycle: drive, check mid-cycle, advance the model across the edge.
  task automatic cyc(input string nm, input logic hs, input logic [1:0] ht, input logic [3:0] sel,
                     input logic [3:0] rdy, input logic [3:0] resp, input logic hr,
                     input logic er, input logic es, input logic [31:0] ed, input errfsm_e est);
    drive(hs, ht, sel, rdy, resp, hr);
    @(negedge HCLK);
    chk({nm, "_rdy"},   {33'b0, bus.HREADYOUT}, {33'b0, er});
    chk({nm, "_resp"},  {33'b0, bus.HRESP},     {33'b0, es});
    chk({nm, "_data"},  {2'b0, bus.HRDATA},     {2'b0, ed});
    chk({nm, "_state"}, {32'b0, dbg_state},     {32'b0, est});
    model_step();
    @(posedge HCLK); #1;
  endtask

  typedef struct {
    logic        hs;
    logic [1:0]  ht;
    logic [3:0]  sel, rdy, resp;
    logic        hr;
    logic        er, es;
    logic [31:0] ed;
    errfsm_e     est;
  } vec_t;

  vec_t tbl [17];

  initial begin
    logic [33:0] e;
    tbl[0]  = '{1'b0, HTRANS_IDLE,   4'h0,    4'hF,    4'h0, 1'b1, 1'b1, 1'b0, 32'h0,         ERR_OK};
    tbl[1]  = '{1'b0, HTRANS_IDLE,   4'h0,    4'hF,    4'h0, 1'b1, 1'b1, 1'b0, 32'h0,         ERR_OK};
    tbl[2]  = '{1'b1, HTRANS_NONSEQ, 4'b0100, 4'hF,    4'h0, 1'b1, 1'b1, 1'b0, 32'h0,         ERR_OK};
    tbl[3]  = '{1'b0, HTRANS_IDLE,   4'h0,    4'b1011, 4'h0, 1'b0, 1'b0, 1'b0, 32'hCAFE_0002, ERR_OK};
    tbl[4]  = '{1'b0, HTRANS_IDLE,   4'h0,    4'b1011, 4'h0, 1'b0, 1'b0, 1'b0, 32'hCAFE_0002, ERR_OK};
    tbl[5]  = '{1'b0, HTRANS_IDLE,   4'h0,    4'hF,    4'h0, 1'b1, 1'b1, 1'b0, 32'hCAFE_0002, ERR_OK};
    tbl[6]  = '{1'b1, HTRANS_NONSEQ, 4'b0010, 4'hF,    4'h0, 1'b1, 1'b1, 1'b0, 32'h0,         ERR_OK};
    tbl[7]  = '{1'b1, HTRANS_NONSEQ, 4'b0010, 4'hF,    4'h0, 1'b0, 1'b0, 1'b1, 32'h0,         ERR_1};
    tbl[8]  = '{1'b1, HTRANS_NONSEQ, 4'b0010, 4'hF,    4'h0, 1'b1, 1'b1, 1'b1, 32'h0,         ERR_2};
    tbl[9]  = '{1'b0, HTRANS_IDLE,   4'h0,    4'hF,    4'h0, 1'b0, 1'b0, 1'b1, 32'h0,         ERR_1};
    tbl[10] = '{1'b0, HTRANS_IDLE,   4'h0,    4'hF,    4'h0, 1'b1, 1'b1, 1'b1, 32'h0,         ERR_2};
    tbl[11] = '{1'b1, HTRANS_IDLE,   4'h0,    4'hF,    4'h0, 1'b1, 1'b1, 1'b0, 32'h0,         ERR_OK};
    tbl[12] = '{1'b1, HTRANS_BUSY,   4'h0,    4'hF,    4'h0, 1'b1, 1'b1, 1'b0, 32'h0,         ERR_OK};
    tbl[13] = '{1'b1, HTRANS_BUSY,   4'h0,    4'hF,    4'h0, 1'b1, 1'b1, 1'b0, 32'h0,         ERR_OK};
    tbl[14] = '{1'b1, HTRANS_NONSEQ, 4'b1100, 4'hF,    4'h0, 1'b1, 1'b1, 1'b0, 32'h0,         ERR_OK};
    tbl[15] = '{1'b0, HTRANS_IDLE,   4'h0,    4'hF,    4'hF, 1'b1, 1'b1, 1'b1, 32'hCAFE_0002, ERR_OK};
    tbl[16] = '{1'b0, HTRANS_IDLE,   4'h0,    4'hF,    4'hF, 1'b1, 1'b1, 1'b0, 32'h0,         ERR_OK};

    // Clock/reset
    for (int i = 0; i < 4; i++) t_rdata[i] = 32'hCAFE_0000 + 32'(i);
    drive(1'b0, HTRANS_IDLE, 4'h0, 4'hF, 4'h0, 1'b1);
    model_reset();
    @(negedge HCLK);
    chk("rst_init_rdy",  {33'b0, bus.HREADYOUT}, 34'd1);
    chk("rst_init_resp", {33'b0, bus.HRESP},     34'd0);
    chk("rst_init_data", {2'b0, bus.HRDATA},     34'd0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    @(posedge HCLK); #1;

    // Directed vector table
    for (int i = 0; i < 17; i++) begin
      cyc($sformatf("vec%0d", i), tbl[i].hs, tbl[i].ht, tbl[i].sel, tbl[i].rdy, tbl[i].resp,
          tbl[i].hr, tbl[i].er, tbl[i].es, tbl[i].ed, tbl[i].est);
    end

    // Asynchronous reset in the middle of an ERROR response
    cyc("rst_addr", 1'b1, HTRANS_NONSEQ, 4'b0010, 4'hF, 4'h0, 1'b1, 1'b1, 1'b0, 32'h0, ERR_OK);
    drive(1'b0, HTRANS_IDLE, 4'h0, 4'hF, 4'h0, 1'b0);
    #2;
    chk("rst_err1_rdy",  {33'b0, bus.HREADYOUT}, 34'd0);
    chk("rst_err1_resp", {33'b0, bus.HRESP},     34'd1);
    HRESETn = 1'b0;
    #1;
    chk("rst_async_rdy",   {33'b0, bus.HREADYOUT}, 34'd1);
    chk("rst_async_resp",  {33'b0, bus.HRESP},     34'd0);
    chk("rst_async_data",  {2'b0, bus.HRDATA},     34'd0);
    chk("rst_async_state", {32'b0, dbg_state},     {32'b0, ERR_OK});
    model_reset();
    @(negedge HCLK);
    HRESETn = 1'b1;
    @(posedge HCLK); #1;
    chk("rst_rel_sel", {31'b0, dbg_sel}, {31'b0, SEL_NONE});
    cyc("rst_rel", 1'b0, HTRANS_IDLE, 4'h0, 4'hF, 4'h0, 1'b1, 1'b1, 1'b0, 32'h0, ERR_OK);

    // Long slave stall, then the just-in-time answer
    cyc("to_addr", 1'b1, HTRANS_NONSEQ, 4'b0001, 4'hF, 4'h0, 1'b1, 1'b1, 1'b0, 32'h0, ERR_OK);
`ifdef AHB_MUX_TIMEOUT_EN
    for (int k = 0; k < TMO; k++)
      cyc("to_stall", 1'b0, HTRANS_IDLE, 4'h0, 4'b1110, 4'h0, 1'b0, 1'b0, 1'b0, 32'hCAFE_0000, ERR_OK);
    cyc("to_err1", 1'b0, HTRANS_IDLE, 4'h0, 4'b1110, 4'h0, 1'b0, 1'b0, 1'b1, 32'h0, ERR_1);
    cyc("to_err2", 1'b0, HTRANS_IDLE, 4'h0, 4'b1110, 4'h0, 1'b1, 1'b1, 1'b1, 32'h0, ERR_2);
    cyc("to_addr2", 1'b1, HTRANS_NONSEQ, 4'b0001, 4'hF, 4'h0, 1'b1, 1'b1, 1'b0, 32'h0, ERR_OK);
    for (int k = 0; k < TMO - 1; k++)
      cyc("to_stall2", 1'b0, HTRANS_IDLE, 4'h0, 4'b1110, 4'h0, 1'b0, 1'b0, 1'b0, 32'hCAFE_0000, ERR_OK);
`else
    for (int k = 0; k < 2 * TMO; k++)
      cyc("to_stall", 1'b0, HTRANS_IDLE, 4'h0, 4'b1110, 4'h0, 1'b0, 1'b0, 1'b0, 32'hCAFE_0000, ERR_OK);
`endif
    cyc("to_win",   1'b0, HTRANS_IDLE, 4'h0, 4'hF, 4'h0, 1'b1, 1'b1, 1'b0, 32'hCAFE_0000, ERR_OK);
    cyc("to_after", 1'b0, HTRANS_IDLE, 4'h0, 4'hF, 4'h0, 1'b1, 1'b1, 1'b0, 32'h0, ERR_OK);

    // Randomized traffic, bus HREADY closed through the model's HREADYOUT
    for (int n = 0; n < 400; n++) begin
      t_hsel_m = 1'($urandom_range(0, 1));
      t_htrans = 2'($urandom_range(0, 3));
      for (int i = 0; i < 4; i++) begin
        t_hsel[i]  = ($urandom_range(0, 3) == 0);
        t_rdy[i]   = ($urandom_range(0, 3) != 0);
        t_resp[i]  = 1'($urandom_range(0, 1));
        t_rdata[i] = $urandom;
      end
      e = model_out();
      t_hready = e[33];
      exp_q.push_back(e);
      @(negedge HCLK);
      chk($sformatf("rand%0d", n), {bus.HREADYOUT, bus.HRESP, bus.HRDATA}, exp_q.pop_front());
      model_step();
      @(posedge HCLK); #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
